// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state encoding, default widths and WS polarity,
// so the upsampler's transmitter and this receiver agree on which level is left.
package i2s_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 6;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_SYNC       = 2'd0,
    ST_RIGHT_SKIP = 2'd1,
    ST_LEFT       = 2'd2,
    ST_RIGHT      = 2'd3
  } rx_state_e;

endpackage

// File: rtl/i2s_deserializer_if.sv
// Parallel sample bus leaving the I2S receiver: one coherent stereo frame per
// sample_valid pulse, plus measured word length and lock status.
interface i2s_deserializer_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

  logic [DATA_WIDTH-1:0] sample_l;
  logic [DATA_WIDTH-1:0] sample_r;
  logic                  sample_valid;
  logic [CNT_WIDTH-1:0]  bits_per_word;
  logic                  locked;

  modport master (
    output sample_l, sample_r, sample_valid, bits_per_word, locked
  );

  modport slave (
    input sample_l, sample_r, sample_valid, bits_per_word, locked
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// Brings the asynchronous BCK/WS/DATA pins into the clk25 domain through 2-FF
// synchronizers and flags each BCK rising edge (bit event) with an extra BCK stage.
module i2s_sync_edge (
  input  logic clk25,
  input  logic reset_n,
  input  logic bck_i,
  input  logic ws_i,
  input  logic data_i,
  output logic bit_event_o,
  output logic ws_o,
  output logic data_o
);

  logic [2:0] pin;
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       bck_dly_q;

  assign pin = {data_i, ws_i, bck_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
          meta_q[gi] <= 1'b0;
          sync_q[gi] <= 1'b0;
        end else begin
          meta_q[gi] <= pin[gi];
          sync_q[gi] <= meta_q[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      bck_dly_q <= 1'b0;
    end else begin
      bck_dly_q <= sync_q[0];
    end
  end

  assign bit_event_o = sync_q[0] & ~bck_dly_q;
  assign ws_o        = sync_q[1];
  assign data_o      = sync_q[2];

endmodule

// File: rtl/i2s_deserializer.sv
// I2S receiver: oversamples BCK/WS/DATA in clk25, deserializes MSB-first words and
// emits one sample_valid per stereo frame. Define I2S_LEFT_JUSTIFIED_EN for left-justified input.
module i2s_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic               clk25,
  input  logic               reset_n,
  input  logic               I2S_BCK,
  input  logic               I2S_WS,
  input  logic               I2S_DATA,
  i2s_deserializer_if.master rx_o
);

  localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic bit_event;
  logic ws_s;
  logic data_s;

  i2s_sync_edge u_sync_edge (
    .clk25       (clk25),
    .reset_n     (reset_n),
    .bck_i       (I2S_BCK),
    .ws_i        (I2S_WS),
    .data_i      (I2S_DATA),
    .bit_event_o (bit_event),
    .ws_o        (ws_s),
    .data_o      (data_s)
  );

  rx_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  ws_prev_q, ws_prev_d;
  logic [DATA_WIDTH-1:0] sample_l_q, sample_l_d;
  logic [DATA_WIDTH-1:0] sample_r_q, sample_r_d;
  logic                  sample_valid_q, sample_valid_d;
  logic [CNT_WIDTH-1:0]  bpw_q, bpw_d;
  logic                  locked_q, locked_d;

  logic                  ws_change;
  logic                  close_word;
  logic [DATA_WIDTH-1:0] stored;
  logic [DATA_WIDTH-1:0] word;
  logic [CNT_WIDTH-1:0]  word_len;

  assign ws_change = ws_s ^ ws_prev_q;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_SYNC;
      cnt_q          <= '0;
      shreg_q        <= '0;
      ws_prev_q      <= 1'b0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
      bpw_q          <= '0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      ws_prev_q      <= ws_prev_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      sample_valid_q <= sample_valid_d;
      bpw_q          <= bpw_d;
      locked_q       <= locked_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    ws_prev_d      = ws_prev_q;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    sample_valid_d = 1'b0;
    bpw_d          = bpw_q;
    locked_d       = locked_q;
    close_word     = 1'b0;
    word           = shreg_q;
    word_len       = cnt_q;
    // Bits past DATA_WIDTH shift out of range and vanish; the word register only ever
    // has zeros below the write position, so OR-ing in the new bit is enough.
    stored         = shreg_q | (data_s ? (MSB_ONE >> cnt_q) : '0);

    if (bit_event) begin
      ws_prev_d = ws_s;
`ifdef I2S_LEFT_JUSTIFIED_EN
      if (ws_change) begin
        close_word = 1'b1;
        word       = shreg_q;
        word_len   = cnt_q;
        shreg_d    = data_s ? MSB_ONE : '0;
        cnt_d      = CNT_ONE;
      end else begin
        shreg_d = stored;
        cnt_d   = sat_inc(cnt_q);
      end
`else
      shreg_d = stored;
      cnt_d   = sat_inc(cnt_q);
      if (ws_change) begin
        close_word = 1'b1;
        word       = stored;
        word_len   = sat_inc(cnt_q);
        shreg_d    = '0;
        cnt_d      = '0;
      end
`endif
    end

    // A close is always a WS edge, so the new WS level tells rise from fall.
    if (close_word) begin
      case (state_q)
        ST_SYNC: begin
          state_d = (ws_s == WS_LEFT) ? ST_LEFT : ST_RIGHT_SKIP;
        end
        ST_RIGHT_SKIP: begin
          if (ws_s == WS_LEFT) state_d = ST_LEFT;
        end
        ST_LEFT: begin
          if (ws_s == WS_RIGHT) begin
            sample_l_d = word;
            bpw_d      = word_len;
            state_d    = ST_RIGHT;
          end
        end
        ST_RIGHT: begin
          if (ws_s == WS_LEFT) begin
            sample_r_d     = word;
            bpw_d          = word_len;
            sample_valid_d = 1'b1;
            locked_d       = 1'b1;
            state_d        = ST_LEFT;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  assign rx_o.sample_l      = sample_l_q;
  assign rx_o.sample_r      = sample_r_q;
  assign rx_o.sample_valid  = sample_valid_q;
  assign rx_o.bits_per_word = bpw_q;
  assign rx_o.locked        = locked_q;

endmodule

// File: tb/tb_i2s_deserializer.sv
// Randomized bench: builds I2S bit streams from word lists and predicts the emitted
// frames from the word values and lengths alone.
module tb_i2s_deserializer;
  import i2s_pkg::*;

  localparam int DW      = 16;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk25   = 1'b0;
  logic reset_n = 1'b0;
  logic bck     = 1'b0;
  logic ws      = 1'b0;
  logic din     = 1'b0;

  always #5 clk25 = ~clk25;

  i2s_deserializer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) rx_if ();

  i2s_deserializer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk25    (clk25),
    .reset_n  (reset_n),
    .I2S_BCK  (bck),
    .I2S_WS   (ws),
    .I2S_DATA (din),
    .rx_o     (rx_if)
  );

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [CW-1:0] bpw;
  } frame_t;

  frame_t exp_q[$];
  bit     ev_ws[$];
  bit     ev_d[$];
  frame_t mon_f;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample = word's first DW bits MSB-first, zero padded when the word is short.
  function automatic logic [DW-1:0] model_sample(input logic [95:0] w, input int n);
    logic [95:0] t;
    if (n >= DW) t = w >> (n - DW);
    else         t = w << (DW - n);
    return t[DW-1:0];
  endfunction

  function automatic logic [CW-1:0] model_bpw(input int n);
    return CW'((n > CNT_MAX) ? CNT_MAX : n);
  endfunction

  function automatic logic [95:0] rand_word(input int n);
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w & ((96'd1 << n) - 96'd1);
  endfunction

  // One entry per BCK rise: the WS level and DATA bit the receiver sees on that edge.
  task automatic add_word(input bit ch, input int n, input logic [95:0] w);
    for (int i = n - 1; i >= 0; i--) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
      ev_ws.push_back(ch);
`else
      ev_ws.push_back((i == 0) ? ~ch : ch);
`endif
      ev_d.push_back(w[i]);
    end
  endtask

  task automatic add_frame(input int nl, input logic [95:0] wl,
                           input int nr, input logic [95:0] wr, input bit emit);
    frame_t f;
    add_word(WS_LEFT, nl, wl);
    add_word(WS_RIGHT, nr, wr);
    if (emit) begin
      f.l   = model_sample(wl, nl);
      f.r   = model_sample(wr, nr);
      f.bpw = model_bpw(nr);
      exp_q.push_back(f);
    end
  endtask

  task automatic play(input int count);
    int k;
    k = 0;
    while (ev_ws.size() > 0 && (count < 0 || k < count)) begin
      @(negedge clk25);
      ws  = ev_ws.pop_front();
      din = ev_d.pop_front();
      repeat (4) @(negedge clk25);
      bck = 1'b1;
      repeat (4) @(negedge clk25);
      bck = 1'b0;
      k++;
    end
  endtask

  task automatic finish_stream();
`ifdef I2S_LEFT_JUSTIFIED_EN
    ev_ws.push_back(WS_LEFT);
    ev_d.push_back(1'b0);
`endif
    play(-1);
  endtask

  task automatic drain(input string tag);
    repeat (20) @(negedge clk25);
    check_val(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk25);
    bck     = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk25);
    reset_n = 1'b1;
    repeat (2) @(negedge clk25);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_l"},      64'(rx_if.sample_l), 64'd0);
    check_val({tag, "_r"},      64'(rx_if.sample_r), 64'd0);
    check_val({tag, "_valid"},  64'(rx_if.sample_valid), 64'd0);
    check_val({tag, "_bpw"},    64'(rx_if.bits_per_word), 64'd0);
    check_val({tag, "_locked"}, 64'(rx_if.locked), 64'd0);
  endtask

  always @(negedge clk25) begin
    if (reset_n && rx_if.sample_valid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 64'd1, 64'd0);
      end else begin
        mon_f = exp_q.pop_front();
        check_val("sample_l", 64'(rx_if.sample_l), 64'(mon_f.l));
        check_val("sample_r", 64'(rx_if.sample_r), 64'(mon_f.r));
        check_val("bits_per_word", 64'(rx_if.bits_per_word), 64'(mon_f.bpw));
        check_val("locked", 64'(rx_if.locked), 64'd1);
      end
      $display("frame L=%h R=%h bpw=%0d", rx_if.sample_l, rx_if.sample_r, rx_if.bits_per_word);
    end
  end

  initial begin
    int nl;
    int nr;
    repeat (3) @(negedge clk25);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk25);

    // 16-bit directed frames; the first frame only establishes alignment.
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b0);
    play(-1);
    repeat (4) @(negedge clk25);
    check_val("locked_before_frame", 64'(rx_if.locked), 64'd0);
    add_frame(16, 96'h1234, 16, 96'hABCD, 1'b1);
    add_frame(16, 96'h00FF, 16, 96'h7F00, 1'b1);
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b1);
    finish_stream();
    drain("pending_16bit");

    apply_reset();
    add_frame(24, rand_word(24), 24, rand_word(24), 1'b0);
    add_frame(24, 96'h123456, 24, 96'hFEDCBA, 1'b1);
    add_frame(12, 96'hFFF, 12, 96'h800, 1'b1);
    finish_stream();
    drain("pending_24_12bit");

    // Stream picked up in the middle of a right word.
    ws = WS_RIGHT;
    apply_reset();
    add_word(WS_RIGHT, 5, rand_word(5));
    for (int i = 0; i < 3; i++) add_frame(16, rand_word(16), 16, rand_word(16), 1'b1);
    finish_stream();
    drain("pending_midright");

    // Random word lengths, including 1-bit words and lengths past counter saturation.
    apply_reset();
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b0);
    for (int i = 0; i < 6; i++) begin
      nl = (i == 0) ? 1 : (i == 1) ? 70 : $urandom_range(1, 40);
      nr = (i == 2) ? 1 : (i == 3) ? 66 : $urandom_range(1, 40);
      add_frame(nl, rand_word(nl), nr, rand_word(nr), 1'b1);
    end
    finish_stream();
    drain("pending_random");

    // Reset pulsed in the middle of a left word.
    apply_reset();
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b0);
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b1);
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b1);
    add_word(WS_LEFT, 16, rand_word(16));
    play(ev_ws.size() - 10);
    repeat (10) @(negedge clk25);
    check_val("pending_prereset", 64'(exp_q.size()), 64'd0);
    @(negedge clk25);
    #2 reset_n = 1'b0;
    #1 check_zero("midreset");
    repeat (3) @(negedge clk25);
    reset_n = 1'b1;
    add_word(WS_RIGHT, 16, rand_word(16));
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b1);
    add_frame(16, rand_word(16), 16, rand_word(16), 1'b1);
    finish_stream();
    drain("pending_postreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_deserializer.md
# i2s_deserializer

Receive-side counterpart to the audio upsampler's I2S output path: oversamples an external I2S stream (BCK/WS/DATA) in the system clock domain, deserializes MSB-first words into parallel left/right samples, and emits one valid pulse per complete stereo frame. It sits between the board I2S pins and any on-chip audio consumer (level metering, volume scaling, re-serialization), and reports the measured word length to the Nios PIO.

## Interface
Parameters:
- DATA_WIDTH, 16: parallel sample width; bits beyond this per word are dropped, missing bits are zero-filled at the LSB end.
- CNT_WIDTH, 6: width of the bit counter and of bits_per_word; the counter saturates at 2^CNT_WIDTH-1.

Ports:
- clk25  in  1  system clock; must be at least 4x the BCK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- I2S_BCK  in  1  asynchronous bit clock.
- I2S_WS  in  1  asynchronous word select; 0 = left, 1 = right.
- I2S_DATA  in  1  asynchronous serial data, MSB first.
- sample_l  out  DATA_WIDTH  last complete left word, two's complement.
- sample_r  out  DATA_WIDTH  last complete right word.
- sample_valid  out  1  one-cycle pulse; sample_l/sample_r form a coherent frame.
- bits_per_word  out  CNT_WIDTH  bit count of the most recent completed word.
- locked  out  1  high once one full left+right frame has been received since reset.

One clock (clk25); reset is asynchronous and active-low (reset_n). All outputs are registered.

## Operation
- Input conditioning: BCK, WS and DATA each pass through a 2-FF synchronizer. A third BCK stage feeds a rising-edge detector; WS and DATA are taken from the synchronizer outputs in the detect cycle.
- On each detected BCK rise ("bit event"), the sampled WS is compared with ws_prev, the WS captured at the previous bit event.
- Standard I2S (macro absent): the bit sampled on a WS-change event is the LSB of the outgoing word. The bit is stored first, then the word is closed.
- Storing a bit: if cnt < DATA_WIDTH, shreg[DATA_WIDTH-1-cnt] <= DATA. Then cnt increments, saturating at all-ones.
- Closing a word: bits_per_word <= cnt+1 (saturating). The word is latched into the channel given by ws_prev. shreg and cnt clear for the next word.
- States:
  - SYNC (reset state): bits are stored, but word closes are only used to transition. First WS fall -> LEFT. First WS rise -> RIGHT_SKIP.
  - RIGHT_SKIP: the next WS fall -> LEFT. The right word is discarded.
  - LEFT: a WS rise latches sample_l -> RIGHT.
  - RIGHT: a WS fall latches sample_r and pulses sample_valid -> LEFT. locked is set on the first such pulse.
- There is no backpressure. A consumer that misses a pulse loses that frame.
- Words longer than DATA_WIDTH are truncated to their MSBs. Shorter words are left-aligned.

## Timing
- Reset values: sample_l = 0, sample_r = 0, sample_valid = 0, bits_per_word = 0, locked = 0, state = SYNC, shreg = 0, cnt = 0, ws_prev = 0.
- Latency: a pin BCK rise becomes a bit event 3 clk25 cycles later (2 sync + 1 edge). The output registers update on the cycle after the bit event. sample_valid and sample_r change in the same cycle.
- sample_l changes mid-frame. Consumers sample it only in the sample_valid cycle.
- If WS toggles on consecutive bit events (a zero-length word), the word closes with bits_per_word = 1. This is not flagged.
- Asserting reset_n mid-word forces all state to its reset values immediately. Reception resumes via SYNC, and the first frame after the next WS fall is the first one emitted.
- A BCK pulse shorter than 2 clk25 periods may be missed; this is out of spec.

## Configuration
- I2S_LEFT_JUSTIFIED_EN defined: left-justified format. WS changes together with the MSB, so on a WS-change bit event the current word is closed first and the bit is stored as bit 0 (MSB) of the new word. bits_per_word then equals cnt, without the +1.
- I2S_LEFT_JUSTIFIED_EN undefined: standard I2S with the one-bit delay, as described in Operation.

## Structure
- Shared package `i2s_pkg`: the state encoding (SYNC, RIGHT_SKIP, LEFT, RIGHT), the default DATA_WIDTH and CNT_WIDTH constants, and the WS_LEFT/WS_RIGHT constants, so that the upsampler and this block agree on WS polarity.
- One sub-module: `i2s_sync_edge`, holding the 3-signal synchronizer and the BCK rising-edge detector. All other logic stays in the top module.

## Test plan
- Standard I2S, 16-bit words, BCK = clk25/8, frames L=16'h1234, R=16'hABCD -> one sample_valid per frame, sample_l=16'h1234, sample_r=16'hABCD, bits_per_word=16, locked rises on the first pulse.
- 24-bit words 24'h123456 / 24'hFEDCBA with DATA_WIDTH=16 -> sample_l=16'h1234, sample_r=16'hFEDC, bits_per_word=24.
- Stream starts mid right word (WS=1 at reset release) -> no sample_valid until after a complete left+right pair; the first emitted frame is the first full one.
- 12-bit words 12'hFFF / 12'h800 -> sample_l=16'hFFF0, sample_r=16'h8000, bits_per_word=12.
- reset_n pulsed low mid left word -> all outputs 0 within the reset cycle, then correct frames with no spurious valid.
- With I2S_LEFT_JUSTIFIED_EN, a left-justified stream with L=16'h00FF, R=16'h7F00 -> matching samples, bits_per_word=16.
